belief_propagation_iteration_controller: RTL
============================================

# belief_propagation_iteration_controller

Control FSM that sequences message-passing iterations of the belief-propagation decoder and drives the data-path iteration up-counter through `increment_count` and `reset_count`, reading its `count` back. It starts each variable-node and check-node update phase, samples the parity-check result after every iteration, and ends decoding on convergence or when the iteration limit is reached. It sits between the top-level decoder handshake and the VN/CN update engines.

## Interface
- `MAX_ITER`, default 10, iteration limit; legal range 1..15.
- `CNT_WIDTH`, default 4, width of the counter value.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a decode; sampled only in IDLE.
- `vn_done`  in  1  VN update engine finished its phase.
- `cn_done`  in  1  CN update engine finished its phase.
- `syndrome_valid`  in  1  the syndrome check result is valid this cycle.
- `syndrome_zero`  in  1  all parity checks are satisfied; qualified by `syndrome_valid`.
- `count`  in  CNT_WIDTH  completed-iteration count from the up-counter.
- `reset_count`  out  1  clears the up-counter.
- `increment_count`  out  1  one-cycle pulse that advances the up-counter.
- `vn_start`, `cn_start`  out  1  one-cycle phase-start pulses.
- `busy`  out  1  high in every state except IDLE.
- `decode_done`  out  1  one-cycle completion pulse.
- `converged`  out  1  latched result; 1 when the syndrome was zero at termination.
- `iterations_used`  out  CNT_WIDTH  latched number of iterations executed.

## Operation
- All outputs are registered.
- States and transitions:
  - IDLE: on `start`, go to INIT.
  - INIT: always lasts 1 cycle, then go to VN.
  - VN: wait for `vn_done`, then go to CN.
  - CN: wait for `cn_done`, then go to CHK.
  - CHK: wait for `syndrome_valid`, then decide (rules below).
  - DONE: always lasts 1 cycle, then go to IDLE.
- INIT:
  - `reset_count`=1 for exactly this cycle.
  - `converged` and `iterations_used` are cleared to 0.
- Entering VN: `vn_start`=1 for exactly the first VN cycle. Entering CN: `cn_start`=1 for exactly the first CN cycle.
- `vn_done` and `cn_done` are accepted from the cycle after the matching start pulse onward. Outside their state they are ignored.
- CHK decision on a cycle with `syndrome_valid`=1:
  - Pulse `increment_count` for one cycle.
  - Latch `iterations_used` = `count`+1. The increment is computed at CNT_WIDTH+1 bits, so there is no wrap.
  - If termination is met (see Configuration), go to DONE. Otherwise go to VN.
- DONE: `decode_done`=1 for one cycle. `converged` and `iterations_used` hold until the next INIT.
- `start` while `busy` is ignored and is not queued.
- `count` is trusted as-is. If `count` ≥ MAX_ITER on a CHK decision, the FSM terminates; it never runs past the limit.
- `reset_n` low mid-operation:
  - State goes to IDLE immediately and asynchronously.
  - All outputs go to reset values.

## Timing
- Reset values:
  - `reset_count`=1, so the counter is held clear during reset.
  - All other outputs are 0, and state is IDLE.
- `reset_count` drops to 0 on the first `clk` edge after `reset_n` deasserts.
- `start` sampled at edge k gives INIT (`reset_count`=1) in cycle k+1 and `vn_start` in cycle k+2.
- Each phase takes at least 2 cycles, and CHK at least 1. Minimum iteration length is 5 cycles.
- `increment_count` and the CHK exit occur in the cycle after `syndrome_valid` is sampled.
- `decode_done` is asserted in the cycle after the final `increment_count`. `busy` falls with the end of DONE.

## Configuration
- `BP_EARLY_TERMINATION_EN` defined:
  - Terminate when `syndrome_zero`=1, or when `count`+1 ≥ MAX_ITER.
  - `converged` = `syndrome_zero`.
- Undefined:
  - Always run exactly MAX_ITER iterations; `syndrome_zero` never ends decoding early.
  - `converged` = `syndrome_zero` sampled at the final CHK.

## Test plan
- Reset held low 3 cycles, then released → `reset_count`=1 during reset and 0 one edge later; `busy`=0; `decode_done`=0.
- MAX_ITER=4, `syndrome_zero`=0 always, `vn_done`/`cn_done` 1 cycle after their start pulses → exactly 4 `increment_count` pulses, one `decode_done`, `iterations_used`=4, `converged`=0.
- With `BP_EARLY_TERMINATION_EN`, `syndrome_zero`=1 at the 2nd CHK → `decode_done` one cycle after the 2nd increment, `iterations_used`=2, `converged`=1. Without the macro, the same stimulus → 4 iterations, `converged` = final sample.
- `start` pulsed during VN, and `cn_done` pulsed during VN → both ignored; the sequence is unchanged.
- `reset_n` asserted in the CN state of iteration 3 → IDLE immediately, all outputs at reset values. A fresh `start` → `reset_count` pulse, then a normal decode from count 0.
- MAX_ITER=1 → one iteration, then `decode_done`; `iterations_used`=1.

Source files
------------

// File: rtl/belief_propagation_iteration_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : belief_propagation_iteration_controller_if                 |
// | Description : Handshake bundle between the BP iteration controller and   |
// |               its surroundings (decoder top, VN/CN engines, syndrome     |
// |               checker, iteration up-counter).                            |
// |   start                 - begin a decode (to controller)                 |
// |   vn_done / cn_done     - update engines finished their phase            |
// |   syndrome_valid/_zero  - parity-check result and its qualifier          |
// |   count                 - completed-iteration count from the up-counter  |
// |   reset_count           - clears the up-counter                          |
// |   increment_count       - one-cycle advance pulse for the up-counter     |
// |   vn_start / cn_start   - one-cycle phase-start pulses                   |
// |   busy                  - controller not idle                            |
// |   decode_done           - one-cycle completion pulse                     |
// |   converged             - latched convergence result                     |
// |   iterations_used       - latched number of iterations executed          |
// |   Modports: slave = controller side, master = environment side.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface belief_propagation_iteration_controller_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 start;
  logic                 vn_done;
  logic                 cn_done;
  logic                 syndrome_valid;
  logic                 syndrome_zero;
  logic [CNT_WIDTH-1:0] count;
  logic                 reset_count;
  logic                 increment_count;
  logic                 vn_start;
  logic                 cn_start;
  logic                 busy;
  logic                 decode_done;
  logic                 converged;
  logic [CNT_WIDTH-1:0] iterations_used;

  modport slave (
    input  start, vn_done, cn_done, syndrome_valid, syndrome_zero, count,
    output reset_count, increment_count, vn_start, cn_start, busy,
           decode_done, converged, iterations_used
  );

  modport master (
    output start, vn_done, cn_done, syndrome_valid, syndrome_zero, count,
    input  reset_count, increment_count, vn_start, cn_start, busy,
           decode_done, converged, iterations_used
  );
endinterface
`default_nettype wire

// File: rtl/belief_propagation_iteration_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : belief_propagation_iteration_controller                    |
// | Description : Control FSM sequencing belief-propagation iterations:      |
// |               INIT -> (VN -> CN -> CHK)* -> DONE. Drives an external     |
// |               iteration up-counter and reads its count back.             |
// | Ports       : clk, reset_n (async, active low) and the slave modport of  |
// |               belief_propagation_iteration_controller_if.                |
// | Parameters  : MAX_ITER (1..15) iteration limit, CNT_WIDTH counter width. |
// | Option      : BP_EARLY_TERMINATION_EN - stop as soon as the syndrome is  |
// |               zero; otherwise always run MAX_ITER iterations.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module belief_propagation_iteration_controller #(
  parameter int MAX_ITER  = 10,
  parameter int CNT_WIDTH = 4
) (
  input  wire logic clk,
  input  wire logic reset_n,
  belief_propagation_iteration_controller_if.slave bus
);

  localparam logic [CNT_WIDTH:0] C_MAX_ITER = (CNT_WIDTH + 1)'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_VN   = 3'd2,
    S_CN   = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 reset_count_q, reset_count_d;
  logic                 increment_count_q, increment_count_d;
  logic                 vn_start_q, vn_start_d;
  logic                 cn_start_q, cn_start_d;
  logic                 busy_q, busy_d;
  logic                 decode_done_q, decode_done_d;
  logic                 converged_q, converged_d;
  logic [CNT_WIDTH-1:0] iterations_used_q, iterations_used_d;

  logic [CNT_WIDTH:0]   w_cnt_plus1;
  logic [CNT_WIDTH-1:0] w_iter_sat;
  logic                 w_limit;
  logic                 w_terminate;

  // One extra bit so count+1 never wraps before the limit compare.
  assign w_cnt_plus1 = {1'b0, bus.count} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign w_iter_sat  = w_cnt_plus1[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                              : w_cnt_plus1[CNT_WIDTH-1:0];
  // Also catches a count already at or beyond the limit.
  assign w_limit     = (w_cnt_plus1 >= C_MAX_ITER);

`ifdef BP_EARLY_TERMINATION_EN
  assign w_terminate = w_limit || bus.syndrome_zero;
`else
  assign w_terminate = w_limit;
`endif

  always_comb begin
    state_d           = state_q;
    increment_count_d = 1'b0;
    converged_d       = converged_q;
    iterations_used_d = iterations_used_q;

    case (state_q)
      S_IDLE: if (bus.start) state_d = S_INIT;
      S_INIT: state_d = S_VN;
      // The done strobes are ignored during the start-pulse cycle so every
      // phase lasts at least two cycles.
      S_VN:   if (bus.vn_done && !vn_start_q) state_d = S_CN;
      S_CN:   if (bus.cn_done && !cn_start_q) state_d = S_CHK;
      S_CHK: begin
        if (bus.syndrome_valid) begin
          increment_count_d = 1'b1;
          iterations_used_d = w_iter_sat;
          if (w_terminate) begin
            state_d     = S_DONE;
            converged_d = bus.syndrome_zero;
          end else begin
            state_d = S_VN;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so pulses line up with
    // the state they belong to.
    reset_count_d = (state_d == S_INIT);
    if (state_d == S_INIT) begin
      converged_d       = 1'b0;
      iterations_used_d = '0;
    end
    vn_start_d    = (state_d == S_VN) && (state_q != S_VN);
    cn_start_d    = (state_d == S_CN) && (state_q != S_CN);
    busy_d        = (state_d != S_IDLE);
    // Completion is flagged the cycle after DONE, i.e. one cycle after the
    // final increment pulse.
    decode_done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      reset_count_q     <= 1'b1;
      increment_count_q <= 1'b0;
      vn_start_q        <= 1'b0;
      cn_start_q        <= 1'b0;
      busy_q            <= 1'b0;
      decode_done_q     <= 1'b0;
      converged_q       <= 1'b0;
      iterations_used_q <= '0;
    end else begin
      state_q           <= state_d;
      reset_count_q     <= reset_count_d;
      increment_count_q <= increment_count_d;
      vn_start_q        <= vn_start_d;
      cn_start_q        <= cn_start_d;
      busy_q            <= busy_d;
      decode_done_q     <= decode_done_d;
      converged_q       <= converged_d;
      iterations_used_q <= iterations_used_d;
    end
  end

  assign bus.reset_count     = reset_count_q;
  assign bus.increment_count = increment_count_q;
  assign bus.vn_start        = vn_start_q;
  assign bus.cn_start        = cn_start_q;
  assign bus.busy            = busy_q;
  assign bus.decode_done     = decode_done_q;
  assign bus.converged       = converged_q;
  assign bus.iterations_used = iterations_used_q;

endmodule
`default_nettype wire
